// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
// Line geometry, port indices and the sequencer state encoding live here.
package mem_arb_pkg;

  localparam int BURST    = 4;
  localparam int BEAT_W   = $clog2(BURST);
  localparam int LINE_OFF = BEAT_W + 2;

  localparam int PORT_I = 0;
  localparam int PORT_D = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT,
    ST_XFER,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; on a tie the port that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = req;
    if (req == 2'b11) win = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I-cache (port 0) and D-cache (port 1),
// sequencing full-line bursts with the ready_mem stall handshake.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        rd_req,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        done,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [BEAT_W-1:0] beat,
  input  logic              ready_mem,
  input  logic [DATA_W-1:0] rdata_mem,
  output logic              read_mem,
  output logic              write_mem,
  output logic [ADDR_W-1:0] addr_mem,
  output logic [DATA_W-1:0] wdata_mem,
  output state_t            state_dbg
);

  // Handshake: a port holds rd_req/wr_req until its done pulse; memory accepts a
  // command by dropping ready_mem, then every cycle with ready_mem=1 in XFER is one beat.

  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << LINE_OFF) - 1);

  state_t      state;
  logic        last_q;
  logic        port_q;
  logic [1:0]  req;
  logic [1:0]  win;
  logic        win_port;
  logic [ADDR_W-1:0] win_addr;

  assign req      = rd_req | wr_req;
  assign win_port = win[1];
  assign win_addr = win_port ? addr1 : addr0;
  assign state_dbg = state;

  // The granted port presents the word for the current beat directly.
  assign wdata_mem = write_mem ? (port_q ? wdata1 : wdata0) : '0;

  rr_arbiter2 u_rr (
    .req  (req),
    .last (last_q),
    .win  (win)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      last_q    <= 1'b1;
      port_q    <= 1'b0;
      gnt       <= '0;
      done      <= '0;
      rvalid    <= '0;
      rdata     <= '0;
      beat      <= '0;
      read_mem  <= 1'b0;
      write_mem <= 1'b0;
      addr_mem  <= '0;
    end else begin
      done   <= '0;
      rvalid <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            port_q    <= win_port;
            gnt       <= win;
            write_mem <= wr_req[win_port];
            read_mem  <= ~wr_req[win_port];
            addr_mem  <= win_addr & ~LINE_MASK;
            beat      <= '0;
            state     <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (!ready_mem) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ready_mem) state <= ST_XFER;
        end
        ST_XFER: begin
          if (ready_mem) begin
            if (read_mem) begin
              rdata  <= rdata_mem;
              rvalid <= gnt;
            end
            if (beat == BEAT_W'(BURST - 1)) begin
              beat      <= '0;
              read_mem  <= 1'b0;
              write_mem <= 1'b0;
              gnt       <= '0;
              done      <= gnt;
              state     <= ST_DONE;
            end else begin
              beat     <= beat + BEAT_W'(1);
              addr_mem <= addr_mem + ADDR_W'(4);
            end
          end
        end
        ST_DONE: begin
          last_q <= port_q;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scripted memory drives ready_mem/rdata_mem and
// every burst is checked beat by beat against hand-computed addresses and data.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk;
  logic        reset;
  logic [1:0]  rd_req, wr_req;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [1:0]  gnt, done, rvalid;
  logic [31:0] rdata;
  logic [BEAT_W-1:0] beat;
  logic        ready_mem;
  logic [31:0] rdata_mem;
  logic        read_mem, write_mem;
  logic [31:0] addr_mem, wdata_mem;
  state_t      state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .done      (done),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .beat      (beat),
    .ready_mem (ready_mem),
    .rdata_mem (rdata_mem),
    .read_mem  (read_mem),
    .write_mem (write_mem),
    .addr_mem  (addr_mem),
    .wdata_mem (wdata_mem),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rpat(input int k);
    return 32'(k) * 32'h1111;
  endfunction

  function automatic logic [31:0] wpat(input int k);
    return 32'hAAAA + 32'(k) * 32'h1111;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},    32'(gnt), 0);
    check({tag, "_done"},   32'(done), 0);
    check({tag, "_rvalid"}, 32'(rvalid), 0);
    check({tag, "_beat"},   32'(beat), 0);
    check({tag, "_rdata"},  rdata, 0);
    check({tag, "_rd"},     32'(read_mem), 0);
    check({tag, "_wr"},     32'(write_mem), 0);
    check({tag, "_addr"},   addr_mem, 0);
    check({tag, "_wdata"},  wdata_mem, 0);
    check({tag, "_state"},  32'(state_dbg), 32'(ST_IDLE));
  endtask

  // Entered at the negedge where the command is first visible; leaves at the
  // negedge after done has dropped, with the arbiter back in IDLE.
  task automatic serve(input int p, input bit wr, input logic [31:0] base,
                       input int wait_cyc, input int stall_at, input int stall_len,
                       input bit drop_in_wait);
    logic [1:0] g;
    g = 2'(1 << p);
    check("cmd_gnt",  32'(gnt), 32'(g));
    check("cmd_rd",   32'(read_mem), 32'(!wr));
    check("cmd_wr",   32'(write_mem), 32'(wr));
    check("cmd_addr", addr_mem, base);
    check("cmd_beat", 32'(beat), 0);
    ready_mem = 1'b0;
    for (int i = 0; i < wait_cyc; i++) begin
      tick();
      if (i == 0 && drop_in_wait) begin
        rd_req[p] = 1'b0;
        wr_req[p] = 1'b0;
      end
      check("wait_cmd",  32'(read_mem | write_mem), 1);
      check("wait_addr", addr_mem, base);
    end
    ready_mem = 1'b1;
    tick();
    for (int k = 0; k < BURST; k++) begin
      if (k == stall_at) begin
        ready_mem = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_beat",   32'(beat), 32'(k));
          check("stall_addr",   addr_mem, base + 32'(4 * k));
          check("stall_rvalid", 32'(rvalid), 0);
        end
        ready_mem = 1'b1;
      end
      check("xfer_beat", 32'(beat), 32'(k));
      check("xfer_addr", addr_mem, base + 32'(4 * k));
      if (wr) begin
        if (p == 1) wdata1 = wpat(k);
        else        wdata0 = wpat(k);
        #1;
        check("xfer_wdata", wdata_mem, wpat(k));
      end else begin
        rdata_mem = rpat(k);
      end
      tick();
      if (wr) begin
        check("wr_rvalid", 32'(rvalid), 0);
      end else begin
        check("rd_rvalid", 32'(rvalid), 32'(g));
        check("rd_rdata",  rdata, rpat(k));
      end
    end
    check("done_pulse", 32'(done), 32'(g));
    check("done_cmd",   32'(read_mem | write_mem), 0);
    check("done_gnt",   32'(gnt), 0);
    tick();
    check("done_clear", 32'(done), 0);
  endtask

  initial begin
    reset = 1'b0; rd_req = '0; wr_req = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    ready_mem = 1'b1; rdata_mem = '0;
    repeat (2) tick();
    check_reset_outputs("rst");
    reset = 1'b1;

    // single read on the I-cache port, memory busy 4 cycles
    rd_req = 2'b01; addr0 = 32'h0000_4013;
    tick();
    serve(PORT_I, 1'b0, 32'h0000_4010, 4, -1, 0, 1'b0);
    rd_req = 2'b00;

    // D-cache write-back, then refill of the same line
    rd_req = 2'b10; wr_req = 2'b10; addr1 = 32'hC000_0FF3;
    tick();
    serve(PORT_D, 1'b1, 32'hC000_0FF0, 2, -1, 0, 1'b0);
    wr_req = 2'b00;
    tick();
    serve(PORT_D, 1'b0, 32'hC000_0FF0, 2, -1, 0, 1'b0);
    rd_req = 2'b00;

    // ties from reset alternate 0,1,0,1; one service stalls mid-burst
    reset = 1'b0;
    tick();
    reset = 1'b1;
    rd_req = 2'b11; addr0 = 32'h0000_1004; addr1 = 32'h0000_2038;
    tick();
    serve(PORT_I, 1'b0, 32'h0000_1000, 1, -1, 0, 1'b0);
    tick();
    serve(PORT_D, 1'b0, 32'h0000_2030, 1, 2, 3, 1'b0);
    tick();
    serve(PORT_I, 1'b0, 32'h0000_1000, 2, -1, 0, 1'b0);
    tick();
    serve(PORT_D, 1'b0, 32'h0000_2030, 1, -1, 0, 1'b0);
    rd_req = 2'b00;

    // reset at beat 1 of a read abandons the burst
    rd_req = 2'b01; addr0 = 32'h0000_5000;
    tick();
    ready_mem = 1'b0;
    tick();
    ready_mem = 1'b1;
    tick();
    rdata_mem = 32'h1234_5678;
    tick();
    check("pre_rst_beat", 32'(beat), 1);
    reset = 1'b0;
    tick();
    check_reset_outputs("midrst");
    reset = 1'b1;
    tick();
    serve(PORT_I, 1'b0, 32'h0000_5000, 1, -1, 0, 1'b0);
    rd_req = 2'b00;

    // request dropped in WAIT still completes
    rd_req = 2'b01; addr0 = 32'h0000_6008;
    tick();
    serve(PORT_I, 1'b0, 32'h0000_6000, 3, -1, 0, 1'b1);
    tick();
    check("idle_after_drop", 32'(gnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
